// File: rtl/game_state_control_if.sv
// Signal bundle between the cursor/click input path and the game state sequencer.
// The sequencer sits on the slave side and the input path sits on the master side.
interface game_state_control_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 click;
  logic                 base1_nuked;
  logic                 base2_nuked;
  logic                 base3_nuked;
  logic [OUT_WIDTH-1:0] killcount;
  logic                 game_rst;
  logic                 game_run;
  logic [1:0]           state;
  logic [2:0]           level;
  logic [1:0]           bases_left;

  modport master (
    output click, base1_nuked, base2_nuked, base3_nuked, killcount,
    input  game_rst, game_run, state, level, bases_left
  );

  modport slave (
    input  click, base1_nuked, base2_nuked, base3_nuked, killcount,
    output game_rst, game_run, state, level, bases_left
  );
endinterface

// File: rtl/game_state_control.sv
// Game-wide sequencer: title, field clear, play and game over.
// It gates the game datapath, latches lost bases and steps the difficulty level.
module game_state_control #(
  parameter int OUT_WIDTH       = 8,
  parameter int KILLS_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 7,
  parameter int CLEAR_CYCLES    = 16,
  parameter int GAMEOVER_HOLD   = 200_000_000
) (
  input logic                  clk,
  input logic                  rst,
  game_state_control_if.slave  bus
);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    CLEAR = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // One counter serves both the CLEAR duration and the OVER hold time.
  localparam int CNT_MAX = (GAMEOVER_HOLD > CLEAR_CYCLES) ? GAMEOVER_HOLD : CLEAR_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]      CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0]      HOLD_DONE  = CW'(GAMEOVER_HOLD);
  localparam logic [OUT_WIDTH:0] KPL        = (OUT_WIDTH + 1)'(KILLS_PER_LEVEL);
  localparam logic [2:0]         LVL_MAX    = 3'(MAX_LEVEL);

  state_t               cur, nxt;
  logic                 click_d;
  logic                 click_edge;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           lost, lost_nxt;
  logic [2:0]           level_q, level_nxt;
  logic [OUT_WIDTH:0]   threshold, threshold_nxt;
  logic [1:0]           lost_cnt;
  logic                 game_rst_nxt, game_run_nxt;
  logic [1:0]           bases_left_nxt;
  logic                 game_rst_q, game_run_q;
  logic [1:0]           bases_left_q;

  assign click_edge = bus.click & ~click_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= TITLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      TITLE: if (click_edge) nxt = CLEAR;
      CLEAR: if (cnt == CLEAR_LAST) nxt = PLAY;
      PLAY:  if (lost_nxt == 3'b111) nxt = OVER;
      OVER:  if ((cnt == HOLD_DONE) && click_edge) nxt = TITLE;
      default: nxt = TITLE;
    endcase
  end

  // Game over takes priority over a level step landing in the same cycle.
  always_comb begin
    cnt_nxt       = cnt;
    lost_nxt      = lost;
    level_nxt     = level_q;
    threshold_nxt = threshold;
    case (cur)
      TITLE: begin
        if (click_edge) begin
          cnt_nxt       = '0;
          lost_nxt      = 3'b000;
          level_nxt     = 3'd0;
          threshold_nxt = KPL;
        end
      end
      CLEAR: begin
        cnt_nxt = (cnt == CLEAR_LAST) ? '0 : cnt + 1'b1;
      end
      PLAY: begin
        lost_nxt = lost | {bus.base3_nuked, bus.base2_nuked, bus.base1_nuked};
        if (lost_nxt == 3'b111) begin
          cnt_nxt = '0;
        end else if (({1'b0, bus.killcount} >= threshold) && (level_q < LVL_MAX)) begin
          level_nxt     = level_q + 3'd1;
          threshold_nxt = threshold + KPL;
        end
      end
      OVER: begin
        if (cnt != HOLD_DONE) cnt_nxt = cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    lost_cnt       = {1'b0, lost_nxt[0]} + {1'b0, lost_nxt[1]} + {1'b0, lost_nxt[2]};
    bases_left_nxt = 2'd3 - lost_cnt;
    game_rst_nxt   = (nxt == TITLE) || (nxt == CLEAR);
    game_run_nxt   = (nxt == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      click_d      <= 1'b1;
      cnt          <= '0;
      lost         <= 3'b000;
      level_q      <= 3'd0;
      threshold    <= KPL;
      game_rst_q   <= 1'b1;
      game_run_q   <= 1'b0;
      bases_left_q <= 2'd3;
    end else begin
      click_d      <= bus.click;
      cnt          <= cnt_nxt;
      lost         <= lost_nxt;
      level_q      <= level_nxt;
      threshold    <= threshold_nxt;
      game_rst_q   <= game_rst_nxt;
      game_run_q   <= game_run_nxt;
      bases_left_q <= bases_left_nxt;
    end
  end

  assign bus.state      = cur;
  assign bus.level      = level_q;
  assign bus.game_rst   = game_rst_q;
  assign bus.game_run   = game_run_q;
  assign bus.bases_left = bases_left_q;

endmodule

// File: tb/tb_game_state_control.sv
// Randomized and directed bench for game_state_control, checked every cycle
// against a behavioural model of the game rules plus literal spot checks.
module tb_game_state_control;
  localparam int K    = 10;
  localparam int MAXL = 7;
  localparam int CLR  = 16;
  localparam int HOLD = 50;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  game_state_control_if #(.OUT_WIDTH(8)) bus ();

  game_state_control #(
    .OUT_WIDTH(8), .KILLS_PER_LEVEL(K), .MAX_LEVEL(MAXL),
    .CLEAR_CYCLES(CLR), .GAMEOVER_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model of the game: phase 0..3, cycles spent in the phase, lost bases, level.
  int m_phase = 0;
  int m_age   = 0;
  bit m_lost [3];
  int m_level = 0;
  bit m_prev_click = 1'b1;

  function automatic int lost_count();
    return int'(m_lost[0]) + int'(m_lost[1]) + int'(m_lost[2]);
  endfunction

  always @(posedge clk) begin
    bit press;
    press = bus.click && !m_prev_click;
    if (rst) begin
      m_phase = 0; m_age = 0; m_level = 0;
      foreach (m_lost[i]) m_lost[i] = 1'b0;
      m_prev_click = 1'b1;
    end else begin
      case (m_phase)
        0: if (press) begin
          m_phase = 1; m_age = 0; m_level = 0;
          foreach (m_lost[i]) m_lost[i] = 1'b0;
        end
        1: begin
          m_age++;
          if (m_age == CLR) begin m_phase = 2; m_age = 0; end
        end
        2: begin
          if (bus.base1_nuked) m_lost[0] = 1'b1;
          if (bus.base2_nuked) m_lost[1] = 1'b1;
          if (bus.base3_nuked) m_lost[2] = 1'b1;
          if (lost_count() == 3) begin
            m_phase = 3; m_age = 0;
          end else if (m_level < MAXL && int'(bus.killcount) >= K * (m_level + 1)) begin
            m_level++;
          end
        end
        default: begin
          if (m_age >= HOLD && press) begin m_phase = 0; m_age = 0; end
          else if (m_age < HOLD) m_age++;
        end
      endcase
      m_prev_click = bus.click;
    end
  end

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_field("state",      32'(bus.state),      32'(m_phase));
    check_field("game_rst",   32'(bus.game_rst),   32'(m_phase <= 1));
    check_field("game_run",   32'(bus.game_run),   32'(m_phase == 2));
    check_field("level",      32'(bus.level),      32'(m_level));
    check_field("bases_left", 32'(bus.bases_left), 32'(3 - lost_count()));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit c, input bit b1, input bit b2, input bit b3, input int kc);
    bus.click = c; bus.base1_nuked = b1; bus.base2_nuked = b2; bus.base3_nuked = b3;
    bus.killcount = 8'(kc);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_field({"lit_", name}, act, exp);
  endtask

  task automatic click_pulse();
    bus.click = 1'b0; tick(1);
    bus.click = 1'b1; tick(1);
    bus.click = 1'b0;
  endtask

  task automatic wait_state(input int target, input int budget);
    int n = 0;
    while (int'(bus.state) != target && n < budget) begin n++; tick(1); end
    checks++;
    if (int'(bus.state) != target) begin
      errors++;
      $display("[TB] FAIL wait_state timeout: state %0d, expected %0d", bus.state, target);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick(3);
    rst = 1'b0;
    tick(3);
    checkOutput("held_click_title", 32'(bus.state), 32'd0);
    checkOutput("held_click_rst",   32'(bus.game_rst), 32'd1);

    bus.click = 1'b0; tick(1);
    bus.click = 1'b1; tick(1);
    checkOutput("enter_clear", 32'(bus.state), 32'd1);
    n = 0;
    while (bus.state == 2'd1 && bus.game_rst && n < 100) begin n++; tick(1); end
    checkOutput("clear_len", 32'(n), 32'd16);
    checkOutput("play_state", 32'(bus.state), 32'd2);
    checkOutput("play_run", 32'(bus.game_run), 32'd1);
    bus.click = 1'b0;

    bus.base2_nuked = 1'b1; tick(1); bus.base2_nuked = 1'b0; tick(2);
    bus.base2_nuked = 1'b1; tick(1); bus.base2_nuked = 1'b0; tick(2);
    checkOutput("base2_twice", 32'(bus.bases_left), 32'd2);
    bus.base1_nuked = 1'b1; tick(5); bus.base1_nuked = 1'b0; tick(2);
    checkOutput("base1_held", 32'(bus.bases_left), 32'd1);
    checkOutput("still_play", 32'(bus.state), 32'd2);

    for (int k = 0; k <= 45; k++) begin bus.killcount = 8'(k); tick(1); end
    tick(2);
    checkOutput("level4", 32'(bus.level), 32'd4);
    rst = 1'b1; tick(1);
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    checkOutput("rst_bases", 32'(bus.bases_left), 32'd3);
    checkOutput("rst_run",   32'(bus.game_run), 32'd0);
    rst = 1'b0; bus.killcount = 8'd0;

    click_pulse();
    wait_state(2, 100);
    for (int k = 0; k <= 75; k++) begin bus.killcount = 8'(k); tick(1); end
    tick(3);
    checkOutput("level_sat", 32'(bus.level), 32'd7);

    rst = 1'b1; tick(1); rst = 1'b0; bus.killcount = 8'd0;
    click_pulse();
    wait_state(2, 100);
    bus.killcount = 8'd35;
    tick(1); checkOutput("jump_l1", 32'(bus.level), 32'd1);
    tick(1); checkOutput("jump_l2", 32'(bus.level), 32'd2);
    tick(1); checkOutput("jump_l3", 32'(bus.level), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 40);
    tick(1);
    checkOutput("over_state", 32'(bus.state), 32'd3);
    checkOutput("over_level", 32'(bus.level), 32'd3);
    checkOutput("over_run",   32'(bus.game_run), 32'd0);
    checkOutput("over_bases", 32'(bus.bases_left), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 40);

    tick(8);
    click_pulse();
    checkOutput("early_click", 32'(bus.state), 32'd3);
    tick(60);
    click_pulse();
    checkOutput("late_click", 32'(bus.state), 32'd0);
    checkOutput("late_rst", 32'(bus.game_rst), 32'd1);
    tick(1);
    click_pulse();
    checkOutput("new_clear", 32'(bus.state), 32'd1);
    checkOutput("new_level", 32'(bus.level), 32'd0);
    checkOutput("new_bases", 32'(bus.bases_left), 32'd3);

    // Random play: sparse nukes, drifting killcount, occasional jumps and resets.
    n = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0) bus.click = ~bus.click;
      bus.base1_nuked = ($urandom_range(0, 59) == 0);
      bus.base2_nuked = ($urandom_range(0, 59) == 0);
      bus.base3_nuked = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) n = int'($urandom_range(0, 255));
      else if ($urandom_range(0, 2) == 0) n = (n + 1) % 256;
      bus.killcount = 8'(n);
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_state_control.md
Name: game_state_control

Overview:
- Top-level sequencer for the game logic datapath.
- Owns the game-wide state: title, field clear, play and game over.
- Holds the enemy/base/fire logic in reset or running via game_rst/game_run.
- Latches lost bases, derives the difficulty level from killcount, and decides game over.
- Sits between the cursor/click input path and the game logic top; runs on the fast clock.

Parameters:
OUT_WIDTH, 8, width of killcount input
KILLS_PER_LEVEL, 10, kills needed per level step
MAX_LEVEL, 7, saturating maximum of level (fits 3 bits)
CLEAR_CYCLES, 16, cycles game_rst is held in CLEAR before play starts
GAMEOVER_HOLD, 200_000_000, cycles in OVER before a click is accepted

Ports:
clk  in  1  fast system clock
rst  in  1  synchronous, active-high reset
click  in  1  fire/select button level
base1_nuked  in  1  base 1 destroyed indication (level)
base2_nuked  in  1  base 2 destroyed indication
base3_nuked  in  1  base 3 destroyed indication
killcount  in  OUT_WIDTH  kill counter from fire control
game_rst  out  1  reset to game logic datapath
game_run  out  1  high while play is active (gates spawn/fire)
state  out  2  TITLE=0, CLEAR=1, PLAY=2, OVER=3
level  out  3  current difficulty level, 0..MAX_LEVEL
bases_left  out  2  3 minus number of latched lost bases

Behaviour:
- Single clock clk; reset synchronous, active-high on rst.
- All outputs are registered and reflect state one cycle after the transition.
- Reset values: state=TITLE, game_rst=1, game_run=0, level=0, bases_left=3, lost flags=000, counters=0, threshold=KILLS_PER_LEVEL.
- Reset value of click_d is 1, so a click held through reset release is not an edge.
- Click edge: click_edge = click & ~click_d; click_d is registered every cycle.
- TITLE:
  - game_rst=1, game_run=0.
  - click_edge -> CLEAR.
- CLEAR:
  - game_rst=1, game_run=0.
  - On entry: cnt=0, level=0, lost=000, threshold=KILLS_PER_LEVEL.
  - cnt increments each cycle; when cnt==CLEAR_CYCLES-1 -> PLAY.
  - game_rst is therefore high for exactly CLEAR_CYCLES cycles in CLEAR.
  - Clicks are ignored.
- PLAY:
  - game_rst=0, game_run=1.
  - lost[i] sets when baseN_nuked is sampled high and is sticky until CLEAR. Repeated or held nuked pulses have no further effect.
  - bases_left = 3 - popcount(lost), updated the cycle after the latch.
  - Level-up: if killcount >= threshold and level < MAX_LEVEL, then level+1 and threshold += KILLS_PER_LEVEL.
  - At most one level step per cycle. A large killcount jump catches up one level per cycle.
  - threshold is OUT_WIDTH+1 bits wide, so there is no wrap at 255.
  - level saturates at MAX_LEVEL.
  - When lost becomes 111 -> OVER. This includes all three bases nuked in the same cycle.
  - Clicks do not change state.
- OVER:
  - game_rst=0, game_run=0; datapath frozen, display kept.
  - level and bases_left are frozen.
  - Hold counter counts GAMEOVER_HOLD cycles; click_edge is ignored while counting.
  - After expiry, click_edge -> TITLE.
- Simultaneous events:
  - Last base lost and level-up condition in the same cycle: OVER wins, level not incremented.
  - rst has priority over every transition.
  - rst mid-PLAY returns to TITLE with reset values on the next edge.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then hold click=1 through rst release -> stays TITLE, game_rst=1. Release and press click -> CLEAR, game_rst high exactly 16 cycles, then state=2, game_run=1.
- In PLAY, pulse base2_nuked 1 cycle twice, and hold base1_nuked 5 cycles -> bases_left 3->2->1, no double count, state stays 2.
- killcount ramps 0..75 -> level increments at 10,20,..,70 and saturates at 7. Jump killcount 0->35 in one cycle -> level 0->3 over 3 consecutive cycles.
- Assert base1..3_nuked in the same cycle with killcount reaching threshold -> state=3 next cycle, level unchanged, game_run=0, bases_left=0.
- In OVER with GAMEOVER_HOLD=50: click at cycle 10 ignored; click after cycle 50 -> TITLE, game_rst=1. Next click -> CLEAR resets level=0, bases_left=3.
- rst asserted mid-PLAY with level=4 -> next cycle state=0, level=0, bases_left=3, game_run=0.
